// File: rtl/vending_pkg.sv
// Shared coin values, acceptor state encoding and the width-window helper.
`timescale 1ns/1ps
package vending_pkg;

    localparam logic [3:0] COIN_1  = 4'd1;
    localparam logic [3:0] COIN_2  = 4'd2;
    localparam logic [3:0] COIN_10 = 4'd10;

    typedef enum logic [2:0] {
        WAIT_LOW,
        IDLE,
        MEASURE,
        CLASSIFY,
        JAM
    } acc_state_t;

    // Inclusive at both edges.
    function automatic logic in_window(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchroniser plus debouncer: dout follows din after DEB_CYCLES equal synced samples.
// Adds 2 + DEB_CYCLES cycles to each edge; no backpressure.
`timescale 1ns/1ps
module coin_debounce #(
    parameter int DEB_CYCLES = 8
) (
    input  logic clk50m,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          dout_q;
    logic          dout_d;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // Any sample equal to the current level restarts the run, so short glitches never flip dout.
    always_comb begin
        dout_d = dout_q;
        cnt_d  = cnt_q;
        if (sync2_q == dout_q) begin
            cnt_d = '0;
        end else if (cnt_q == DW'(DEB_CYCLES - 1)) begin
            dout_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk50m) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dout_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin sensor front end: debounce, measure pulse width in us ticks, classify into coin strobes.
// Strobes follow the raw falling edge by about DEB_CYCLES+3 cycles; no backpressure, strobes unbuffered.
`timescale 1ns/1ps
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int PRESCALE   = 50,
    parameter int DEB_CYCLES = 8,
    parameter int CNT_W      = 8,
    parameter int W1_LO      = 10,
    parameter int W1_HI      = 19,
    parameter int W2_LO      = 20,
    parameter int W2_HI      = 29,
    parameter int W10_LO     = 40,
    parameter int W10_HI     = 59,
    parameter int MAX_TICKS  = 100
) (
    input  logic       clk50m,
    input  logic       rst,
    input  logic       sense,
    input  logic       inhibit,
    output logic [3:0] coin,
    output logic       new_coin,
    output logic       reject,
    output logic       jam
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] WIDTH_SAT = {CNT_W{1'b1}};

    logic             deb;
    logic             deb_prev_q;
    logic             deb_rise;
    logic             deb_fall;

    logic [PW-1:0]    pre_q;
    logic [PW-1:0]    pre_d;
    logic             tick;

    acc_state_t       state_q;
    acc_state_t       state_d;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] width_d;
    logic [3:0]       coin_q;
    logic [3:0]       coin_d;
    logic             new_coin_q;
    logic             new_coin_d;
    logic             reject_q;
    logic             reject_d;
    logic             jam_q;
    logic             jam_d;

    logic             win_hit;
    logic [3:0]       win_val;

    coin_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk50m(clk50m),
        .rst   (rst),
        .din   (sense),
        .dout  (deb)
    );

    assign deb_rise = deb & ~deb_prev_q;
    assign deb_fall = ~deb & deb_prev_q;

    assign tick  = (pre_q == PW'(PRESCALE - 1));
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    always_comb begin
        win_hit = 1'b0;
        win_val = 4'd0;
        if (in_window(int'(width_q), W1_LO, W1_HI)) begin
            win_hit = 1'b1;
            win_val = COIN_1;
        end else if (in_window(int'(width_q), W2_LO, W2_HI)) begin
            win_hit = 1'b1;
            win_val = COIN_2;
        end else if (in_window(int'(width_q), W10_LO, W10_HI)) begin
            win_hit = 1'b1;
            win_val = COIN_10;
        end
    end

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        coin_d     = coin_q;
        new_coin_d = 1'b0;
        reject_d   = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                if (!deb) state_d = IDLE;
            end
            IDLE: begin
                if (deb_rise) begin
                    state_d = MEASURE;
                    width_d = '0;
                end
            end
            MEASURE: begin
                if (tick && (width_q != WIDTH_SAT)) width_d = width_q + CNT_W'(1);
                if (deb_fall) begin
                    state_d = CLASSIFY;
                end else if (width_q > CNT_W'(MAX_TICKS)) begin
                    state_d  = JAM;
                    reject_d = 1'b1;
                end
            end
            CLASSIFY: begin
                state_d = IDLE;
                if (win_hit && !inhibit) begin
                    coin_d     = win_val;
                    new_coin_d = 1'b1;
                end else begin
                    reject_d = 1'b1;
                end
            end
            JAM: begin
                if (!deb) state_d = IDLE;
            end
            default: state_d = WAIT_LOW;
        endcase
        jam_d = (state_d == JAM);
    end

    always_ff @(posedge clk50m) begin
        if (rst) begin
            deb_prev_q <= 1'b1;
            pre_q      <= '0;
            state_q    <= WAIT_LOW;
            width_q    <= '0;
            coin_q     <= 4'd0;
            new_coin_q <= 1'b0;
            reject_q   <= 1'b0;
            jam_q      <= 1'b0;
        end else begin
            deb_prev_q <= deb;
            pre_q      <= pre_d;
            state_q    <= state_d;
            width_q    <= width_d;
            coin_q     <= coin_d;
            new_coin_q <= new_coin_d;
            reject_q   <= reject_d;
            jam_q      <= jam_d;
        end
    end

    assign coin     = coin_q;
    assign new_coin = new_coin_q;
    assign reject   = reject_q;
    assign jam      = jam_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomised and directed coin pulses against a per-pulse outcome model.
`timescale 1ns/1ps
module tb_coin_acceptor;

    localparam int P    = 5;
    localparam int DEB  = 8;
    localparam int MAXT = 100;
    localparam int K_ACC = 0;
    localparam int K_REJ = 1;
    localparam int K_JAM = 2;

    logic       clk50m = 1'b0;
    logic       rst = 1'b1;
    logic       sense = 1'b1;
    logic       inhibit = 1'b0;
    logic [3:0] coin;
    logic       new_coin;
    logic       reject;
    logic       jam;

    coin_acceptor #(.PRESCALE(P)) dut (
        .clk50m  (clk50m),
        .rst     (rst),
        .sense   (sense),
        .inhibit (inhibit),
        .coin    (coin),
        .new_coin(new_coin),
        .reject  (reject),
        .jam     (jam)
    );

    always #10 clk50m = ~clk50m;

    typedef struct {
        int kind;
        int val;
        int t0;
        int lo;
        int hi;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  exp_coin = 0;
    bit  chk_en = 1'b0;
    bit  jam_ok = 1'b0;

    always @(posedge clk50m) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Outcome of one sense pulse of the given length in microsecond ticks.
    function automatic ev_t predict(input int ticks, input bit inh);
        ev_t e;
        e.t0 = 0;
        e.val = 0;
        e.lo = 10;
        e.hi = 14;
        if (ticks > MAXT) begin
            e.kind = K_JAM;
            e.lo = (MAXT + 1) * P;
            e.hi = (MAXT + 1) * P + 25;
        end else if (inh) begin
            e.kind = K_REJ;
        end else if (ticks >= 10 && ticks <= 19) begin
            e.kind = K_ACC;
            e.val = 1;
        end else if (ticks >= 20 && ticks <= 29) begin
            e.kind = K_ACC;
            e.val = 2;
        end else if (ticks >= 40 && ticks <= 59) begin
            e.kind = K_ACC;
            e.val = 10;
        end else begin
            e.kind = K_REJ;
        end
        return e;
    endfunction

    function automatic bit near_edge(input int t);
        return t inside {9, 10, 19, 20, 29, 30, 39, 40, 59, 60};
    endfunction

    always @(negedge clk50m) begin
        if (rst) begin
            exp_coin = 0;
        end else if (chk_en) begin
            if (new_coin && reject) chk("strobe_exclusive", 1, 0);
            if (new_coin || reject) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", int'(new_coin) * 2 + int'(reject), 0);
                end else begin
                    ev_t e;
                    int kind;
                    e = exp_q.pop_front();
                    kind = new_coin ? K_ACC : (jam ? K_JAM : K_REJ);
                    chk("strobe_kind", kind, e.kind);
                    chk_rng("strobe_latency", cyc - e.t0, e.lo, e.hi);
                    if (e.kind == K_ACC) exp_coin = e.val;
                end
            end
            chk("coin_value", int'(coin), exp_coin);
            if (!jam_ok) chk("jam_idle", int'(jam), 0);
        end
    end

    task automatic coin_pulse(input int ticks, input bit inh, input int gap);
        ev_t e;
        inhibit = inh;
        e = predict(ticks, inh);
        @(negedge clk50m);
        sense = 1'b1;
        repeat (ticks * P) @(negedge clk50m);
        sense = 1'b0;
        e.t0 = cyc;
        exp_q.push_back(e);
        repeat (gap) @(negedge clk50m);
    endtask

    initial begin
        ev_t ej;
        int  t;
        bit  inh;

        // Reset held with a coin in the sensor, then the coin leaves: nothing credited.
        rst = 1'b1;
        sense = 1'b1;
        repeat (10) @(negedge clk50m);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_coin", int'(coin), 0);
        chk("reset_new_coin", int'(new_coin), 0);
        chk("reset_reject", int'(reject), 0);
        chk("reset_jam", int'(jam), 0);
        repeat (100) @(negedge clk50m);
        sense = 1'b0;
        repeat (30) @(negedge clk50m);

        coin_pulse(15, 1'b0, 30);
        chk("coin_after_15", int'(coin), 1);
        coin_pulse(25, 1'b0, 30);
        chk("coin_after_25", int'(coin), 2);
        coin_pulse(50, 1'b0, 30);
        chk("coin_after_50", int'(coin), 10);
        coin_pulse(10, 1'b0, 30);
        chk("coin_after_10", int'(coin), 1);
        coin_pulse(59, 1'b0, 30);
        chk("coin_after_59", int'(coin), 10);

        coin_pulse(5, 1'b0, 30);
        coin_pulse(35, 1'b0, 30);
        coin_pulse(70, 1'b0, 30);
        chk("coin_after_rejects", int'(coin), 10);

        coin_pulse(25, 1'b1, 30);
        chk("coin_after_inhibit", int'(coin), 10);
        inhibit = 1'b0;

        // Stuck sensor.
        jam_ok = 1'b1;
        ej = predict(120, 1'b0);
        @(negedge clk50m);
        sense = 1'b1;
        ej.t0 = cyc;
        exp_q.push_back(ej);
        repeat (120 * P) @(negedge clk50m);
        chk("jam_set", int'(jam), 1);
        sense = 1'b0;
        repeat (5) @(negedge clk50m);
        chk("jam_hold", int'(jam), 1);
        repeat (20) @(negedge clk50m);
        chk("jam_clear", int'(jam), 0);
        jam_ok = 1'b0;
        coin_pulse(15, 1'b0, 30);
        chk("coin_after_jam", int'(coin), 1);

        // Glitches shorter than the debounce run.
        for (int g = 0; g < 6; g++) begin
            @(negedge clk50m);
            sense = 1'b1;
            repeat ((g % 2 == 0) ? 2 : DEB - 1) @(negedge clk50m);
            sense = 1'b0;
            repeat (15) @(negedge clk50m);
        end

        // Reset in the middle of a coin.
        @(negedge clk50m);
        sense = 1'b1;
        repeat (10 * P) @(negedge clk50m);
        rst = 1'b1;
        repeat (3) @(negedge clk50m);
        rst = 1'b0;
        repeat (15 * P) @(negedge clk50m);
        sense = 1'b0;
        repeat (30) @(negedge clk50m);
        chk("coin_after_midreset", int'(coin), 0);
        coin_pulse(25, 1'b0, 30);
        chk("coin_after_recovery", int'(coin), 2);

        for (int i = 0; i < 40; i++) begin
            do t = int'($urandom_range(95, 3)); while (near_edge(t));
            inh = ($urandom_range(3, 0) == 0);
            coin_pulse(t, inh, 20 + int'($urandom_range(17, 0)));
        end
        inhibit = 1'b0;

        repeat (40) @(negedge clk50m);
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            chk("missing_strobe_kind", -1, e.kind);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
